core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 120 ++++++++++++
 tb/tb_core_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Program sequencer: holds a small instruction memory and replays its first
// `length` words `iterations` times as a gap-free, registered instruction stream.
module core_sequencer #(
    parameter int PROG_DEPTH = 64,
    parameter int ITER_W     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_valid_i,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr_i,
    input  logic [16:0]                   load_data_i,
    input  logic                          start_i,
    input  logic [$clog2(PROG_DEPTH):0]   length_i,
    input  logic [ITER_W-1:0]             iterations_i,
    input  logic                          abort_i,
    output logic [16:0]                   instruction_o,
    output logic                          instr_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(PROG_DEPTH)-1:0] pc_o,
    output logic [ITER_W-1:0]             iter_o
);

    localparam int AW = $clog2(PROG_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_e;

    state_e            state, state_next;
    logic [16:0]       mem [PROG_DEPTH];
    logic [AW:0]       len_q;
    logic [ITER_W-1:0] iters_q;

    logic              issue;
    logic [AW-1:0]     rd_pc;
    logic [ITER_W-1:0] rd_iter;
    logic              params_ok;
    logic              pass_end;
    logic              last_instr;

    assign params_ok  = (length_i != '0) && (length_i <= (AW+1)'(PROG_DEPTH))
                        && (iterations_i != '0);
    // iter_o never exceeds iters_q-1, so the counter cannot wrap even at all-ones.
    assign pass_end   = ({1'b0, pc_o} == len_q - (AW+1)'(1));
    assign last_instr = pass_end && (iter_o == iters_q - ITER_W'(1));

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        rd_pc      = '0;
        rd_iter    = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = params_ok ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (abort_i) begin
                    state_next = DONE;
                end else begin
                    issue      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort_i || last_instr) begin
                    state_next = DONE;
                end else begin
                    issue = 1'b1;
                    if (pass_end) begin
                        rd_iter = iter_o + ITER_W'(1);
                    end else begin
                        rd_pc   = pc_o + AW'(1);
                        rd_iter = iter_o;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the program memory has no reset; its contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (load_valid_i && (state == IDLE)) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // Output register doubles as the memory read register, giving the
    // one-cycle read latency while keeping instruction_o zero when not issuing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            instruction_o <= '0;
            instr_valid_o <= 1'b0;
            pc_o          <= '0;
            iter_o        <= '0;
            len_q         <= '0;
            iters_q       <= '0;
        end else begin
            state         <= state_next;
            instr_valid_o <= issue;
            instruction_o <= issue ? mem[rd_pc] : '0;
            if (issue) begin
                pc_o   <= rd_pc;
                iter_o <= rd_iter;
            end
            if ((state == IDLE) && start_i) begin
                len_q   <= length_i;
                iters_q <= iterations_i;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-cycle comparison against an
// arithmetic reference model plus directed scenarios with literal expectations.
module tb_core_sequencer;

    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int ITER_W = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              load_valid_i;
    logic [AW-1:0]     load_addr_i;
    logic [16:0]       load_data_i;
    logic              start_i;
    logic [AW:0]       length_i;
    logic [ITER_W-1:0] iterations_i;
    logic              abort_i;
    logic [16:0]       instruction_o;
    logic              instr_valid_o;
    logic              busy_o;
    logic              done_o;
    logic [AW-1:0]     pc_o;
    logic [ITER_W-1:0] iter_o;

    core_sequencer #(.PROG_DEPTH(DEPTH), .ITER_W(ITER_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_valid_i  (load_valid_i),
        .load_addr_i   (load_addr_i),
        .load_data_i   (load_data_i),
        .start_i       (start_i),
        .length_i      (length_i),
        .iterations_i  (iterations_i),
        .abort_i       (abort_i),
        .instruction_o (instruction_o),
        .instr_valid_o (instr_valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pc_o          (pc_o),
        .iter_o        (iter_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: a run is just the index sequence k = 0..len*iters-1,
    // with pc = k % len and pass = k / len.
    logic [16:0]       m_mem [DEPTH];
    int                m_len, m_total, m_k;
    logic              exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic [16:0]       exp_instr = '0;
    logic [AW-1:0]     exp_pc = '0;
    logic [ITER_W-1:0] exp_iter = '0;

    int valid_count = 0;
    int done_count  = 0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_instr = '0;   exp_pc = '0;     exp_iter = '0;
        end
        check("instruction", 32'(instruction_o), 32'(exp_instr));
        check("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
        check("busy",        32'(busy_o),        32'(exp_busy));
        check("done",        32'(done_o),        32'(exp_done));
        check("pc",          32'(pc_o),          32'(exp_pc));
        check("iter",        32'(iter_o),        32'(exp_iter));
        if (instr_valid_o) valid_count++;
        if (done_o) done_count++;
        if (rst_ni) begin
            if (!exp_busy) begin
                if (load_valid_i) m_mem[load_addr_i] = load_data_i;
                if (start_i) begin
                    exp_busy = 1'b1;
                    if (length_i == 0 || int'(length_i) > DEPTH || iterations_i == 0) begin
                        exp_done = 1'b1;
                    end else begin
                        m_len   = int'(length_i);
                        m_total = int'(length_i) * int'(iterations_i);
                        m_k     = 0;
                    end
                end
            end else if (exp_done) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else if (abort_i || m_k == m_total) begin
                exp_done  = 1'b1;
                exp_valid = 1'b0;
                exp_instr = '0;
            end else begin
                exp_valid = 1'b1;
                exp_instr = m_mem[m_k % m_len];
                exp_pc    = AW'(m_k % m_len);
                exp_iter  = ITER_W'(m_k / m_len);
                m_k++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        load_valid_i = 1'b0; load_addr_i = '0; load_data_i = '0;
        start_i = 1'b0; length_i = '0; iterations_i = '0; abort_i = 1'b0;
    endtask

    task automatic start_run(input int len, input int iters);
        start_i = 1'b1; length_i = (AW+1)'(len); iterations_i = ITER_W'(iters);
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        bit hit;
        cycles = 0;
        hit = 1'b0;
        while (!hit && cycles < budget) begin
            @(negedge clk_i);
            cycles++;
            hit = done_o;
        end
        if (!hit) check("done_timeout", 32'(done_o), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy_o && c < budget) begin
            step();
            c++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
        step();
    endtask

    logic [16:0]       lit_instr [6] = '{17'h00A1, 17'h00B2, 17'h00C3, 17'h00A1, 17'h00B2, 17'h00C3};
    logic [ITER_W-1:0] lit_iter  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};

    initial begin
        int c;
        rst_ni = 1'b0;
        clear_inputs();
        #1;
        check("rst_instruction", 32'(instruction_o), 32'd0);
        check("rst_valid",       32'(instr_valid_o), 32'd0);
        check("rst_busy",        32'(busy_o),        32'd0);
        check("rst_done",        32'(done_o),        32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Fill the whole memory so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            load_valid_i = 1'b1; load_addr_i = AW'(i); load_data_i = 17'($urandom);
            step();
        end
        clear_inputs();

        // Three-word program, two passes.
        for (int i = 0; i < 3; i++) begin
            load_valid_i = 1'b1; load_addr_i = AW'(i); load_data_i = lit_instr[i];
            step();
        end
        load_valid_i = 1'b0;
        start_run(3, 2);
        @(negedge clk_i);
        check("fetch_busy", 32'(busy_o), 32'd1);
        check("fetch_valid", 32'(instr_valid_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("seq_valid", 32'(instr_valid_o), 32'd1);
            check("seq_instr", 32'(instruction_o), 32'(lit_instr[i]));
            check("seq_iter",  32'(iter_o),        32'(lit_iter[i]));
        end
        @(negedge clk_i);
        check("seq_done", 32'(done_o), 32'd1);
        wait_idle(10);

        // Zero length: straight to a single DONE cycle.
        valid_count = 0;
        start_run(0, 3);
        wait_done(10, c);
        check("len0_latency", 32'(c), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check("len0_busy_after", 32'(busy_o), 32'd0);
        check("len0_valid_count", 32'(valid_count), 32'd0);
        wait_idle(10);

        // Abort on the third valid cycle.
        valid_count = 0; done_count = 0;
        start_run(4, 3);
        step(); step(); step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        wait_idle(20);
        check("abort_valid_count", 32'(valid_count), 32'd3);
        check("abort_done_count",  32'(done_count),  32'd1);

        // Load and start attempts mid-run are ignored.
        for (int i = 0; i < 5; i++) begin
            load_valid_i = 1'b1; load_addr_i = AW'(i); load_data_i = 17'(17'h10 + i);
            step();
        end
        load_valid_i = 1'b0;
        valid_count = 0;
        start_run(5, 2);
        step(); step();
        load_valid_i = 1'b1; load_addr_i = 6'd1; load_data_i = 17'h1FFFF;
        start_i = 1'b1; length_i = 7'd1; iterations_i = 8'd1;
        step();
        clear_inputs();
        wait_done(40, c);
        check("midrun_valid_count", 32'(valid_count), 32'd10);
        wait_idle(10);
        start_run(2, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        check("midrun_mem_kept", 32'(instruction_o), 32'h00011);
        wait_idle(10);

        // Asynchronous reset in the middle of a run.
        done_count = 0;
        start_run(8, 4);
        step(); step(); step(); step();
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_instruction", 32'(instruction_o), 32'd0);
        check("arst_valid",       32'(instr_valid_o), 32'd0);
        check("arst_busy",        32'(busy_o),        32'd0);
        check("arst_pc",          32'(pc_o),          32'd0);
        check("arst_iter",        32'(iter_o),        32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step(); step(); step();
        check("arst_no_done", 32'(done_count), 32'd0);

        // Full-depth single pass.
        valid_count = 0;
        start_run(64, 1);
        wait_done(100, c);
        check("full_latency", 32'(c), 32'd66);
        check("full_valid_count", 32'(valid_count), 32'd64);
        check("full_pc_held", 32'(pc_o), 32'd63);
        wait_idle(10);

        // Maximum iteration count.
        valid_count = 0;
        start_run(2, 255);
        wait_done(600, c);
        check("maxiter_latency", 32'(c), 32'd512);
        check("maxiter_valid_count", 32'(valid_count), 32'd510);
        check("maxiter_iter_held", 32'(iter_o), 32'd254);
        wait_idle(10);

        // Random traffic; the per-cycle model comparison does the checking.
        for (int n = 0; n < 4000; n++) begin
            load_valid_i = ($urandom_range(0, 3) == 0);
            load_addr_i  = AW'($urandom);
            load_data_i  = 17'($urandom);
            start_i      = ($urandom_range(0, 7) == 0);
            length_i     = ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom_range(60, 70))
                                                       : (AW+1)'($urandom_range(0, 8));
            iterations_i = ITER_W'($urandom_range(0, 3));
            abort_i      = ($urandom_range(0, 31) == 0);
            step();
        end
        clear_inputs();
        wait_idle(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
